// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator RAM read-modify-write path.
package acc_pkg;

    localparam int ACC_ADDR_W = 13;
    localparam int ACC_DATA_W = 32;
    localparam int ACC_WORDS  = 2048;

    localparam logic [ACC_DATA_W-1:0] ACC_MAX = 32'h7FFF_FFFF;
    localparam logic [ACC_DATA_W-1:0] ACC_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        FETCH,
        RDOUT
    } acc_state_e;

endpackage

// File: rtl/acc_add_sat.sv
// Signed 32-bit adder with overflow detect and optional clamp to ACC_MAX/ACC_MIN.
module acc_add_sat
    import acc_pkg::*;
(
    input  logic [ACC_DATA_W-1:0] a,
    input  logic [ACC_DATA_W-1:0] b,
    input  logic                  sat,
    output logic [ACC_DATA_W-1:0] sum,
    output logic                  ovf
);

    logic [ACC_DATA_W:0] wide;

    // Overflow shows up as disagreement between the sign-extension bit and the result sign.
    always_comb begin
        wide = {a[ACC_DATA_W-1], a} + {b[ACC_DATA_W-1], b};
        ovf  = wide[ACC_DATA_W] ^ wide[ACC_DATA_W-1];
        sum  = wide[ACC_DATA_W-1:0];
        if (ovf && sat) begin
            sum = a[ACC_DATA_W-1] ? ACC_MIN : ACC_MAX;
        end
    end

endmodule

// File: rtl/acc_update.sv
// Read-modify-write front end for the accumulator RAM, plus a low-priority read-out port.
module acc_update
    import acc_pkg::*;
#(
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  upd_valid_i,
    output logic                  upd_ready_o,
    input  logic [ACC_ADDR_W-1:0] upd_addr_i,
    input  logic [ACC_DATA_W-1:0] upd_data_i,
    input  logic                  upd_init_i,
    input  logic                  rd_valid_i,
    output logic                  rd_ready_o,
    input  logic [ACC_ADDR_W-1:0] rd_addr_i,
    output logic                  rd_valid_o,
    output logic [ACC_DATA_W-1:0] rd_data_o,
    output logic                  ovf_o,
    output logic                  busy_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [ACC_ADDR_W-1:0] ram_w_addr_o,
    output logic [ACC_ADDR_W-1:0] ram_r_addr_o,
    output logic [ACC_DATA_W-1:0] ram_wdata_o,
    input  logic [ACC_DATA_W-1:0] ram_rdata_i
);

    acc_state_e            state;
    logic [ACC_ADDR_W-1:0] addr_q;
    logic [ACC_DATA_W-1:0] op_q;
    logic                  init_q;
    logic                  ovf_q;

    logic                  accept_window;
    logic                  upd_fire;
    logic                  rd_fire;
    logic [ACC_DATA_W-1:0] add_sum;
    logic                  add_ovf;

    acc_add_sat u_add (
        .a   (ram_rdata_i),
        .b   (op_q),
        .sat (SATURATE),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Updates always win; read-out only gets a slot when no update is pending.
    always_comb begin
        accept_window = (state == IDLE) || (state == WRITE) || (state == RDOUT);
        upd_ready_o   = accept_window;
        rd_ready_o    = accept_window && !upd_valid_i;
        upd_fire      = upd_valid_i && upd_ready_o;
        rd_fire       = rd_valid_i && rd_ready_o;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr_q <= '0;
            op_q   <= '0;
            init_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (state == WRITE && !init_q && add_ovf) begin
                ovf_q <= 1'b1;
            end
            case (state)
                IDLE, WRITE, RDOUT: begin
                    if (upd_fire) begin
                        addr_q <= upd_addr_i;
                        op_q   <= upd_data_i;
                        init_q <= upd_init_i;
                        state  <= READ;
                    end else if (rd_fire) begin
                        addr_q <= rd_addr_i;
                        state  <= FETCH;
                    end else begin
                        state  <= IDLE;
                    end
                end
                READ:    state <= WRITE;
                FETCH:   state <= RDOUT;
                default: state <= IDLE;
            endcase
        end
    end

    // RAM read data arrives during WRITE/RDOUT, so the data paths are decoded from state directly.
    always_comb begin
        ram_en_o     = 1'b0;
        ram_we_o     = 1'b0;
        ram_wdata_o  = '0;
        rd_valid_o   = 1'b0;
        rd_data_o    = '0;
        case (state)
            READ, FETCH: ram_en_o = 1'b1;
            WRITE: begin
                ram_en_o    = 1'b1;
                ram_we_o    = 1'b1;
                ram_wdata_o = init_q ? op_q : add_sum;
            end
            RDOUT: begin
                rd_valid_o = 1'b1;
                rd_data_o  = ram_rdata_i;
            end
            default: ;
        endcase
        ram_w_addr_o = addr_q;
        ram_r_addr_o = addr_q;
        ovf_o        = ovf_q;
        busy_o       = (state != IDLE);
    end

endmodule

// File: tb/tb_acc_update.sv
// Drives a wrapping and a saturating acc_update from one stimulus stream against a word-level reference model.
module tb_acc_update;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        upd_valid;
    logic [12:0] upd_addr;
    logic [31:0] upd_data;
    logic        upd_init;
    logic        rd_valid;
    logic [12:0] rd_addr;

    logic        upd_ready0, rd_ready0, rd_valid0, ovf0, busy0, ram_en0, ram_we0;
    logic [31:0] rd_data0, ram_wdata0;
    logic [12:0] ram_w_addr0, ram_r_addr0;
    logic [31:0] ram_rdata0 = '0;

    logic        upd_ready1, rd_ready1, rd_valid1, ovf1, busy1, ram_en1, ram_we1;
    logic [31:0] rd_data1, ram_wdata1;
    logic [12:0] ram_w_addr1, ram_r_addr1;
    logic [31:0] ram_rdata1 = '0;

    logic [31:0] mem0 [2048] = '{default: '0};
    logic [31:0] mem1 [2048] = '{default: '0};
    int          wr_cnt0 = 0;
    int          wr_cnt1 = 0;

    logic [31:0] exp0 [2048] = '{default: '0};
    logic [31:0] exp1 [2048] = '{default: '0};
    bit          m_ovf0 = 1'b0;
    bit          m_ovf1 = 1'b0;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    acc_update #(.SATURATE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .upd_valid_i(upd_valid), .upd_ready_o(upd_ready0), .upd_addr_i(upd_addr),
        .upd_data_i(upd_data), .upd_init_i(upd_init),
        .rd_valid_i(rd_valid), .rd_ready_o(rd_ready0), .rd_addr_i(rd_addr),
        .rd_valid_o(rd_valid0), .rd_data_o(rd_data0), .ovf_o(ovf0), .busy_o(busy0),
        .ram_en_o(ram_en0), .ram_we_o(ram_we0), .ram_w_addr_o(ram_w_addr0),
        .ram_r_addr_o(ram_r_addr0), .ram_wdata_o(ram_wdata0), .ram_rdata_i(ram_rdata0)
    );

    acc_update #(.SATURATE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .upd_valid_i(upd_valid), .upd_ready_o(upd_ready1), .upd_addr_i(upd_addr),
        .upd_data_i(upd_data), .upd_init_i(upd_init),
        .rd_valid_i(rd_valid), .rd_ready_o(rd_ready1), .rd_addr_i(rd_addr),
        .rd_valid_o(rd_valid1), .rd_data_o(rd_data1), .ovf_o(ovf1), .busy_o(busy1),
        .ram_en_o(ram_en1), .ram_we_o(ram_we1), .ram_w_addr_o(ram_w_addr1),
        .ram_r_addr_o(ram_r_addr1), .ram_wdata_o(ram_wdata1), .ram_rdata_i(ram_rdata1)
    );

    // Single-port RAMs with one-cycle read latency, word-indexed by byte address [12:2].
    always @(posedge clk) begin
        if (ram_en0) begin
            if (ram_we0) begin
                mem0[ram_w_addr0[12:2]] <= ram_wdata0;
                wr_cnt0 <= wr_cnt0 + 1;
            end else begin
                ram_rdata0 <= mem0[ram_r_addr0[12:2]];
            end
        end
    end

    always @(posedge clk) begin
        if (ram_en1) begin
            if (ram_we1) begin
                mem1[ram_w_addr1[12:2]] <= ram_wdata1;
                wr_cnt1 <= wr_cnt1 + 1;
            end else begin
                ram_rdata1 <= mem1[ram_r_addr1[12:2]];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] refResult(input logic [31:0] old, input logic [31:0] d,
                                              input bit init, input bit sat, output bit ovf);
        longint s;
        longint lim;
        ovf = 1'b0;
        if (init) return d;
        lim = 64'sd2147483647;
        s   = longint'($signed(old)) + longint'($signed(d));
        if (s > lim || s < -lim - 1) begin
            ovf = 1'b1;
            if (sat) return (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end
        return s[31:0];
    endfunction

    task automatic modelUpdate(input logic [12:0] addr, input logic [31:0] data, input bit init);
        logic [10:0] idx;
        bit          o0;
        bit          o1;
        idx       = addr[12:2];
        exp0[idx] = refResult(exp0[idx], data, init, 1'b0, o0);
        exp1[idx] = refResult(exp1[idx], data, init, 1'b1, o1);
        if (o0) m_ovf0 = 1'b1;
        if (o1) m_ovf1 = 1'b1;
    endtask

    // Presents one update, waits for acceptance and reports the cycle it was taken in.
    task automatic applyStimulus(input logic [12:0] addr, input logic [31:0] data, input bit init,
                                 output int t_acc);
        int waited = 0;
        @(negedge clk);
        upd_valid = 1'b1;
        upd_addr  = addr;
        upd_data  = data;
        upd_init  = init;
        #1;
        while (!upd_ready0 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        t_acc = cyc;
        if (!upd_ready0) begin
            checkOutput("upd_accept_timeout", 32'(upd_ready0), 32'd1);
            upd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        modelUpdate(addr, data, init);
    endtask

    task automatic checkRead(input int t_acc, input logic [12:0] addr, input string tag);
        int          waited = 0;
        logic [10:0] idx;
        idx = addr[12:2];
        @(negedge clk);
        while (!rd_valid0 && waited < 6) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_valid0"}, 32'(rd_valid0), 32'd1);
        checkOutput({tag, "_valid1"}, 32'(rd_valid1), 32'd1);
        checkOutput({tag, "_latency"}, 32'(cyc - t_acc), 32'd2);
        checkOutput({tag, "_data_wrap"}, rd_data0, exp0[idx]);
        checkOutput({tag, "_data_sat"}, rd_data1, exp1[idx]);
        checkOutput({tag, "_ovf_wrap"}, 32'(ovf0), 32'(m_ovf0));
        checkOutput({tag, "_ovf_sat"}, 32'(ovf1), 32'(m_ovf1));
    endtask

    task automatic readBack(input logic [12:0] addr, input string tag);
        int waited = 0;
        int t_acc;
        @(negedge clk);
        rd_valid = 1'b1;
        rd_addr  = addr;
        #1;
        while (!rd_ready0 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        t_acc = cyc;
        if (!rd_ready0) begin
            checkOutput({tag, "_rd_accept_timeout"}, 32'(rd_ready0), 32'd1);
            rd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
        checkRead(t_acc, addr, tag);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_upd_ready"}, 32'({upd_ready0, upd_ready1}), 32'd3);
        checkOutput({tag, "_rd_ready"}, 32'({rd_ready0, rd_ready1}), 32'd3);
        checkOutput({tag, "_busy"}, 32'({busy0, busy1}), 32'd0);
        checkOutput({tag, "_ram_ctl"}, 32'({ram_en0, ram_we0, ram_en1, ram_we1}), 32'd0);
        checkOutput({tag, "_ovf"}, 32'({ovf0, ovf1}), 32'd0);
        checkOutput({tag, "_rd_valid"}, 32'({rd_valid0, rd_valid1}), 32'd0);
        checkOutput({tag, "_rd_data"}, rd_data0 | rd_data1, 32'd0);
        checkOutput({tag, "_wdata"}, ram_wdata0 | ram_wdata1, 32'd0);
        checkOutput({tag, "_addr"}, 32'(ram_w_addr0 | ram_r_addr0 | ram_w_addr1 | ram_r_addr1), 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          t;
        int          t_prev;
        int          w0;
        int          w1;
        logic [10:0] pool [8];

        rst_n     = 1'b0;
        upd_valid = 1'b0;
        upd_addr  = '0;
        upd_data  = '0;
        upd_init  = 1'b0;
        rd_valid  = 1'b0;
        rd_addr   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(13'h0010, 32'd5, 1'b1, t);
        readBack(13'h0010, "init");
        checkOutput("init_value", rd_data0, 32'd5);

        applyStimulus(13'h000C, 32'd100, 1'b1, t_prev);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(13'h000C, 32'hFFFF_FFF9, 1'b0, t);
            checkOutput("acc_spacing", 32'(t - t_prev), 32'd2);
            t_prev = t;
        end
        readBack(13'h000C, "acc");
        checkOutput("acc_final", rd_data0, 32'hFFFF_FFD8);
        checkOutput("acc_no_ovf", 32'(ovf0), 32'd0);

        // Update and read-out presented together; read-out must wait for the WRITE slot.
        @(negedge clk);
        upd_valid = 1'b1;
        upd_addr  = 13'h0010;
        upd_data  = 32'h0000_0011;
        upd_init  = 1'b0;
        rd_valid  = 1'b1;
        rd_addr   = 13'h0010;
        #1;
        checkOutput("arb_upd_ready", 32'(upd_ready0), 32'd1);
        checkOutput("arb_rd_ready_idle", 32'(rd_ready0), 32'd0);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        modelUpdate(13'h0010, 32'h0000_0011, 1'b0);
        checkOutput("arb_rd_ready_read", 32'(rd_ready0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("arb_rd_ready_write", 32'(rd_ready0), 32'd1);
        t = cyc;
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
        checkRead(t, 13'h0010, "arb");
        checkOutput("arb_post_update", rd_data0, 32'h0000_0016);

        applyStimulus(13'h0040, 32'h7FFF_FFF0, 1'b1, t);
        applyStimulus(13'h0040, 32'h0000_0020, 1'b0, t);
        checkOutput("ovf_in_read", 32'(ovf0), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("ovf_in_write", 32'(ovf0), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("ovf_after_write", 32'({ovf0, ovf1}), 32'd3);
        readBack(13'h0040, "ovf");
        checkOutput("ovf_wrap_value", rd_data0, 32'h8000_0010);
        checkOutput("ovf_sat_value", rd_data1, 32'h7FFF_FFFF);

        applyStimulus(13'h1FFE, 32'hCAFE_0001, 1'b1, t);
        readBack(13'h1FFC, "wrap_addr");
        checkOutput("wrap_addr_value", rd_data0, 32'hCAFE_0001);

        // Reset lands in READ: the pending update must never reach the RAM.
        @(negedge clk);
        upd_valid = 1'b1;
        upd_addr  = 13'h0200;
        upd_data  = 32'h0000_0055;
        upd_init  = 1'b1;
        #1;
        checkOutput("rst_upd_ready", 32'(upd_ready0), 32'd1);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        w0 = wr_cnt0;
        w1 = wr_cnt1;
        checkOutput("rst_in_read_busy", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkResetOutputs("midrst");
        @(posedge clk);
        #1;
        checkOutput("midrst_no_write", 32'((wr_cnt0 - w0) + (wr_cnt1 - w1)), 32'd0);
        m_ovf0 = 1'b0;
        m_ovf1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        readBack(13'h0200, "midrst_word");

        for (int i = 0; i < 8; i++) pool[i] = 11'((i * 263 + 5) % 2048);
        for (int i = 0; i < 150; i++) begin
            logic [12:0] a;
            logic [31:0] d;
            a = {pool[$urandom_range(0, 7)], 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) == 0) begin
                readBack(a, "rand_rd");
            end else begin
                if ($urandom_range(0, 1) == 0) d = 32'($urandom_range(0, 2000)) - 32'd1000;
                else d = $urandom;
                applyStimulus(a, d, ($urandom_range(0, 3) == 0), t);
            end
        end
        for (int i = 0; i < 8; i++) readBack({pool[i], 2'b00}, "final_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_update.md
# acc_update

Read-modify-write front end for the 32-bit accumulator RAM (2048 words × 32 bit, single-port, 1-cycle read latency, 13-bit byte address). Accepts partial sums from the MAC array over a valid/ready handshake and adds each one into the addressed accumulator word. Also serves a low-priority read-out port that the result drain uses to stream final sums off-chip. Sits directly upstream of the accumulator RAM and owns all of its control pins.

## Interface
- `SATURATE`, default 0: 1 = signed saturating add, 0 = two's-complement wrap.
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `upd_valid_i` input 1: update request valid.
- `upd_ready_o` output 1: update request accepted this cycle when both are high.
- `upd_addr_i` input 13: byte address; only [12:2] is used, [1:0] is ignored.
- `upd_data_i` input 32: signed partial sum.
- `upd_init_i` input 1: 1 = overwrite the word with `upd_data_i` (first K-slice); 0 = accumulate.
- `rd_valid_i` input 1: read-out request.
- `rd_ready_o` output 1: read-out request accepted when both are high.
- `rd_addr_i` input 13: byte address for read-out.
- `rd_valid_o` output 1: one-cycle pulse; `rd_data_o` valid.
- `rd_data_o` output 32: read-out data.
- `ovf_o` output 1: sticky overflow or saturation flag.
- `busy_o` output 1: high in any state other than IDLE.
- `ram_en_o` output 1: RAM enable, active-high.
- `ram_we_o` output 1: RAM write enable, active-high.
- `ram_w_addr_o` output 13: RAM write address.
- `ram_r_addr_o` output 13: RAM read address.
- `ram_wdata_o` output 32: RAM write data.
- `ram_rdata_i` input 32: RAM read data, valid the cycle after a read.

## Operation
- FSM states: IDLE, READ, WRITE, FETCH, RDOUT.
- Registers: `addr_q` (13 bit), `op_q` (32 bit), `init_q`, `ovf_q`.
- `upd_ready_o` is high in IDLE, WRITE and RDOUT.
- `rd_ready_o` is high in those same states, and only when `upd_valid_i` is 0. Update always has priority.
- On update accept: latch address, data and init, then go to READ.
- On read-out accept: latch address, then go to FETCH.
- With no accept, WRITE and RDOUT return to IDLE.
- READ: `ram_en_o=1`, `ram_we_o=0`, `ram_r_addr_o=addr_q`. Next state is WRITE.
- WRITE: `ram_en_o=1`, `ram_we_o=1`, `ram_w_addr_o=addr_q`.
  - `ram_wdata_o` = `op_q` if `init_q`, else `ram_rdata_i + op_q`.
  - The add is 33-bit signed internally.
  - Overflow is detected when both operands have the same sign and the result sign differs. Overflow sets `ovf_q`.
  - If `SATURATE`=1, the result clamps to 0x7FFFFFFF (positive overflow) or 0x80000000 (negative overflow).
  - `init_q=1` never sets the overflow flag.
- FETCH: `ram_en_o=1`, `ram_we_o=0`, `ram_r_addr_o=addr_q`. Next state is RDOUT.
- RDOUT: `rd_valid_o=1`, `rd_data_o=ram_rdata_i`. There is no backpressure on read-out data.
- Back-to-back updates to the same address need no forwarding. The WRITE of update N completes before the READ of update N+1.
- Outside READ, WRITE and FETCH: `ram_en_o=0`, `ram_we_o=0`.
- `ram_w_addr_o` and `ram_r_addr_o` are both driven from `addr_q` at all times.
- Address wrap: byte address 0x1FFC maps to word 2047. There is no bounds check.

## Timing
- Reset: state IDLE. All outputs are 0 except `upd_ready_o=1` and `rd_ready_o=1`. `addr_q`, `op_q` and `ovf_q` are cleared.
- Reset asserted mid-operation aborts the operation.
  - An abort in READ writes nothing.
  - An abort in WRITE: the write cycle already presented completes at the RAM, but the FSM returns to IDLE.
- Update accepted at cycle T: READ at T+1, RAM write at T+2.
- Sustained update throughput is one per 2 cycles, because a new update is accepted during WRITE.
- Read-out accepted at T: FETCH at T+1, `rd_valid_o` at T+2.
- Simultaneous `upd_valid_i` and `rd_valid_i`: the update wins and `rd_ready_o=0`. A continuous update stream starves read-out by design; the sequencer guarantees drain happens only after compute ends.
- `ovf_o` is set the cycle after the offending WRITE. It clears only on reset.

## Structure
- Shared package `acc_pkg`:
  - `ACC_ADDR_W=13`, `ACC_DATA_W=32`, `ACC_WORDS=2048`.
  - The state enum.
  - `ACC_MAX`/`ACC_MIN` saturation constants.
- One combinational sub-module, `acc_add_sat`: inputs a, b and sat; outputs sum and ovf. Reusable by the drain stage.

## Test plan
- Reset and init: reset, then update addr 0x0010 with data 5 and init=1, then read-out 0x0010. Required: `rd_data_o`=5, and `rd_valid_o` exactly 2 cycles after the read-out accept.
- Accumulate: init word 3 with 100, then 20 updates of −7 to the same address, back-to-back. Required: final 100−140=−40 (0xFFFFFFD8), accepts every 2nd cycle, `ovf_o`=0.
- Overflow: init 0x7FFFFFF0, then add 0x20.
  - `SATURATE`=0: result 0x80000010, `ovf_o`=1.
  - `SATURATE`=1: result 0x7FFFFFFF, `ovf_o`=1.
- Arbitration: `upd_valid_i` and `rd_valid_i` asserted in the same IDLE cycle. Required: update accepted, `rd_ready_o`=0; read-out accepted in the following WRITE cycle only after `upd_valid_i` drops. The read returns the post-update value.
- Address handling: update byte address 0x1FFE, then read 0x1FFC. Required: same word (index 2047), value returned.
- Mid-op reset: assert `rst_n`=0 in a READ cycle. Required: no RAM write, all outputs at reset values next cycle, `ovf_o` cleared.
